// File: rtl/fruit_spawner.sv
// fruit_spawner: places a fruit on a 16x16 grid at a pseudo-random cell that never
// coincides with the character, counts fruits eaten, and respawns after each hit.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   reset        in   synchronous, active-high
//   enable       in   game running; 0 freezes FSM, score and outputs
//   hit          in   fruit==char level flag from the hit detector
//   charx/chary  in   character column/row (4 bits each)
//   fruitx/fruity out registered fruit column/row
//   fruit_valid  out  fruit on grid and eligible to be eaten
//   spawn_pulse  out  one-cycle strobe in the cycle a new position first appears
//   score        out  fruits eaten, saturating at 255
module fruit_spawner #(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       hit,
  input  logic [3:0] charx,
  input  logic [3:0] chary,
  output logic [3:0] fruitx,
  output logic [3:0] fruity,
  output logic       fruit_valid,
  output logic       spawn_pulse,
  output logic [7:0] score
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0] SeedEff = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  localparam int unsigned TryW = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [TryW-1:0] TryMax = TryW'(MAX_TRIES);
  localparam logic [TryW-1:0] TryOne = TryW'(1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSpawn  = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  logic [7:0]      lfsr_q, lfsr_d;
  logic [1:0]      state_q, state_d;
  logic [3:0]      fruitx_q, fruitx_d;
  logic [3:0]      fruity_q, fruity_d;
  logic            valid_q, valid_d;
  logic            pulse_q, pulse_d;
  logic [7:0]      score_q, score_d;
  logic [TryW-1:0] retry_q, retry_d;

  logic       feedback;
  logic [3:0] cand_x;
  logic [3:0] cand_y;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign cand_x   = lfsr_q[3:0];
  assign cand_y   = lfsr_q[7:4];

  always_comb begin
    lfsr_d   = {lfsr_q[6:0], feedback};  // free-running, independent of enable
    state_d  = state_q;
    fruitx_d = fruitx_q;
    fruity_d = fruity_q;
    valid_d  = valid_q;
    pulse_d  = 1'b0;
    score_d  = score_q;
    retry_d  = retry_q;

    if (enable) begin
      case (state_q)
        StIdle: begin
          state_d = StSpawn;
        end
        StSpawn: begin
          if (retry_q == TryMax) begin
            // Half-grid offset in x always lands on a cell other than the character.
            fruitx_d = charx + 4'd8;
            fruity_d = chary;
            valid_d  = 1'b1;
            pulse_d  = 1'b1;
            retry_d  = '0;
            state_d  = StActive;
          end else if ((cand_x != charx) || (cand_y != chary)) begin
            fruitx_d = cand_x;
            fruity_d = cand_y;
            valid_d  = 1'b1;
            pulse_d  = 1'b1;
            retry_d  = '0;
            state_d  = StActive;
          end else begin
            retry_d = retry_q + TryOne;
          end
        end
        StActive: begin
          if (hit) begin
            valid_d = 1'b0;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            state_d = StSpawn;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= SeedEff;
      state_q  <= StIdle;
      fruitx_q <= 4'd0;
      fruity_q <= 4'd0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      score_q  <= 8'd0;
      retry_q  <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      state_q  <= state_d;
      fruitx_q <= fruitx_d;
      fruity_q <= fruity_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
      score_q  <= score_d;
      retry_q  <= retry_d;
    end
  end

  assign fruitx      = fruitx_q;
  assign fruity      = fruity_q;
  assign fruit_valid = valid_q;
  // Strobe is suppressed while the game is paused.
  assign spawn_pulse = pulse_q & enable;
  assign score       = score_q;

endmodule

// File: tb/tb_fruit_spawner.sv
// Testbench for fruit_spawner. Three instances share inputs:
//   d0: seed 8'h01, MAX_TRIES 4   d1: seed 8'h01, MAX_TRIES 1   d2: seed 8'h00, MAX_TRIES 4
module tb_fruit_spawner;

  localparam int unsigned Tries0 = 4;

  typedef struct {
    logic [3:0] fx;
    logic [3:0] fy;
    logic       v;
    logic       p;
    logic [7:0] s;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ht;
    logic [3:0] cx;
    logic [3:0] cy;
    exp_t       e0;
    exp_t       e1;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       hit;
  logic [3:0] charx;
  logic [3:0] chary;

  logic [3:0] fx0, fy0, fx1, fy1, fx2, fy2;
  logic       fv0, sp0, fv1, sp1, fv2, sp2;
  logic [7:0] sc0, sc1, sc2;

  int   checks;
  int   errors;
  int   exp_score;
  exp_t sb[$];
  vec_t vecs[15];
  vec_t tail[3];

  fruit_spawner #(.LFSR_SEED(8'h01), .MAX_TRIES(Tries0)) d0 (
    .clk(clk), .reset(reset), .enable(enable), .hit(hit), .charx(charx), .chary(chary),
    .fruitx(fx0), .fruity(fy0), .fruit_valid(fv0), .spawn_pulse(sp0), .score(sc0)
  );

  fruit_spawner #(.LFSR_SEED(8'h01), .MAX_TRIES(1)) d1 (
    .clk(clk), .reset(reset), .enable(enable), .hit(hit), .charx(charx), .chary(chary),
    .fruitx(fx1), .fruity(fy1), .fruit_valid(fv1), .spawn_pulse(sp1), .score(sc1)
  );

  fruit_spawner #(.LFSR_SEED(8'h00), .MAX_TRIES(Tries0)) d2 (
    .clk(clk), .reset(reset), .enable(enable), .hit(hit), .charx(charx), .chary(chary),
    .fruitx(fx2), .fruity(fy2), .fruit_valid(fv2), .spawn_pulse(sp2), .score(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cmp_dut(input string tag, input logic [3:0] fx, input logic [3:0] fy,
                         input logic v, input logic p, input logic [7:0] s, input exp_t e);
    chk({tag, ".fruitx"}, int'(fx), int'(e.fx));
    chk({tag, ".fruity"}, int'(fy), int'(e.fy));
    chk({tag, ".valid"}, int'(v), int'(e.v));
    chk({tag, ".pulse"}, int'(p), int'(e.p));
    chk({tag, ".score"}, int'(s), int'(e.s));
  endtask

  function automatic vec_t mk(input bit r, input bit en, input bit h, input int cx, input int cy,
                              input int fx, input int fy, input bit v, input bit p, input int s);
    vec_t t;
    t.rst   = r;
    t.en    = en;
    t.ht    = h;
    t.cx    = 4'(cx);
    t.cy    = 4'(cy);
    t.e0.fx = 4'(fx);
    t.e0.fy = 4'(fy);
    t.e0.v  = v;
    t.e0.p  = p;
    t.e0.s  = 8'(s);
    t.e1    = t.e0;
    return t;
  endfunction

  // Drive one vector, clock once, then compare all three instances.
  task automatic apply(input string tag, input vec_t t);
    exp_t e;
    reset  = t.rst;
    enable = t.en;
    hit    = t.ht;
    charx  = t.cx;
    chary  = t.cy;
    sb.push_back(t.e0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp_dut({tag, ".d0"}, fx0, fy0, fv0, sp0, sc0, e);
    cmp_dut({tag, ".d2"}, fx2, fy2, fv2, sp2, sc2, e);
    cmp_dut({tag, ".d1"}, fx1, fy1, fv1, sp1, sc1, t.e1);
  endtask

  // d0 must be ACTIVE on entry. Pulses hit for one cycle, checks the score update and,
  // optionally, that a fresh fruit away from the character appears in time.
  task automatic eat(input bit wait_respawn);
    exp_t e;
    bit   found;
    charx     = 4'($urandom_range(0, 15));
    chary     = 4'($urandom_range(0, 15));
    hit       = 1'b1;
    exp_score = (exp_score == 255) ? 255 : exp_score + 1;
    e.fx      = 4'd0;
    e.fy      = 4'd0;
    e.v       = 1'b0;
    e.p       = 1'b0;
    e.s       = 8'(exp_score);
    sb.push_back(e);
    @(posedge clk);
    #1;
    hit = 1'b0;
    e   = sb.pop_front();
    chk("eat.valid_low", int'(fv0), int'(e.v));
    chk("eat.score", int'(sc0), int'(e.s));
    if (wait_respawn) begin
      found = 1'b0;
      for (int k = 0; k < int'(Tries0) + 2 && !found; k++) begin
        @(posedge clk);
        #1;
        if (fv0) found = 1'b1;
      end
      chk("eat.respawn_in_time", int'(found), 1);
      if (found) begin
        chk("eat.respawn_pulse", int'(sp0), 1);
        chk("eat.fruit_ne_char", int'({fx0, fy0} == {charx, chary}), 0);
      end
    end
  endtask

  initial begin
    bit found;
    checks    = 0;
    errors    = 0;
    exp_score = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    hit       = 1'b0;
    charx     = 4'd5;
    chary     = 4'd5;

    // LFSR from 8'h01: 01 02 04 08 11 23 47 8E 1C 38 ...
    vecs[0]  = mk(1, 1, 0, 5, 5,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 5, 5,  0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 5, 5,  2, 0, 1, 1, 0);
    vecs[3]  = mk(0, 1, 0, 5, 5,  2, 0, 1, 0, 0);
    vecs[4]  = mk(0, 1, 1, 5, 5,  2, 0, 0, 0, 1);
    vecs[5]  = mk(0, 1, 0, 5, 5,  1, 1, 1, 1, 1);
    vecs[6]  = mk(0, 0, 1, 5, 5,  1, 1, 1, 0, 1);
    vecs[7]  = mk(0, 0, 1, 5, 5,  1, 1, 1, 0, 1);
    vecs[8]  = mk(0, 1, 1, 5, 5,  1, 1, 0, 0, 2);
    vecs[9]  = mk(0, 1, 1, 5, 5, 12, 1, 1, 1, 2);  // stale hit in SPAWN not counted
    vecs[10] = mk(0, 1, 0, 5, 5, 12, 1, 1, 0, 2);
    vecs[11] = mk(1, 1, 0, 5, 5,  0, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 2, 0,  0, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, 2, 0,  0, 0, 0, 0, 0);  // candidate (2,0) rejected
    vecs[14] = mk(0, 1, 0, 2, 0,  4, 0, 1, 1, 0);
    vecs[14].e1.fx = 4'd10;                        // MAX_TRIES=1 falls back to (2+8,0)

    tail[0] = mk(1, 1, 0, 5, 5,  0, 0, 0, 0, 0);
    tail[1] = mk(0, 1, 0, 5, 5,  0, 0, 0, 0, 0);
    tail[2] = mk(0, 1, 0, 5, 5,  2, 0, 1, 1, 0);

    for (int i = 0; i < 15; i++) apply($sformatf("v%0d", i), vecs[i]);

    // Score saturation with randomized character positions.
    exp_score = 0;
    for (int i = 0; i < 258; i++) eat(1'b1);

    // Reset, bring up, eat 7, then reset while in SPAWN.
    apply("rst_a", tail[0]);
    exp_score = 0;
    reset     = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(posedge clk);
      #1;
      if (fv0) found = 1'b1;
    end
    chk("bringup.valid", int'(found), 1);
    for (int i = 0; i < 6; i++) eat(1'b1);
    eat(1'b0);
    for (int i = 0; i < 3; i++) apply($sformatf("tail%0d", i), tail[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
